// File: rtl/porta_entrada_fifo_pkg.sv
// Shared address map and status layout for the memory-mapped input port.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package porta_entrada_fifo_pkg;

    typedef logic [7:0] byte_t;

    // Peripheral window on endereco_mem, shared with the output port map
    localparam byte_t END_BASE   = 8'hF0;
    localparam byte_t END_DADO   = END_BASE;
    localparam byte_t END_STATUS = 8'(END_BASE + 8'h01);

    // Status byte bit positions
    localparam int ST_NAO_VAZIO = 7;
    localparam int ST_CHEIO     = 6;
    localparam int ST_UNDERRUN  = 5;
    localparam int ST_OCUP_MSB  = 2;
    localparam int ST_OCUP_LSB  = 0;

    // Packs the status byte; bits 4:3 stay zero
    function automatic byte_t monta_status(input logic nv, input logic ch,
                                           input logic und, input logic [2:0] ocup);
        byte_t s;
        s = '0;
        s[ST_NAO_VAZIO]             = nv;
        s[ST_CHEIO]                 = ch;
        s[ST_UNDERRUN]              = und;
        s[ST_OCUP_MSB:ST_OCUP_LSB]  = ocup;
        return s;
    endfunction

endpackage

// File: rtl/porta_entrada_fifo_if.sv
// Producer handshake plus processor read bus of the input port.
// Latency: n/a (wiring only).
// Backpressure: producer holds entrada while entrada_pronta is low.
interface porta_entrada_fifo_if;
    import porta_entrada_fifo_pkg::*;

    byte_t entrada;
    logic  entrada_valida;
    logic  entrada_pronta;
    byte_t endereco;
    logic  leitura;
    byte_t dado_out;
    logic  nao_vazio;

    // Side driving the producer and processor strobes
    modport master (
        output entrada, entrada_valida, endereco, leitura,
        input  entrada_pronta, dado_out, nao_vazio
    );

    // The port itself
    modport slave (
        input  entrada, entrada_valida, endereco, leitura,
        output entrada_pronta, dado_out, nao_vazio
    );

endinterface

// File: rtl/porta_entrada_fifo_fifo_sincrona.sv
// Small synchronous FIFO: storage array, read/write pointers, occupancy count.
// Latency: push visible at head on the next edge; head is combinational from rd pointer.
// Backpressure: push ignored when full, pop ignored when empty.
module fifo_sincrona #(
    parameter int PROFUNDIDADE = 4,
    parameter int LARGURA      = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic [LARGURA-1:0] dado_in,
    input  logic               pop,
    output logic [LARGURA-1:0] dado_head,
    output logic               cheio,
    output logic               vazio,
    output logic [3:0]         ocupacao
);

    localparam int              AW  = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
    localparam logic [AW-1:0]   ULT = AW'(PROFUNDIDADE - 1);
    localparam logic [3:0]      CAP = 4'(PROFUNDIDADE);

    logic [LARGURA-1:0] mem [PROFUNDIDADE];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               push_ok;
    logic               pop_ok;

    assign cheio     = (ocupacao == CAP);
    assign vazio     = (ocupacao == 4'd0);
    assign push_ok   = push & ~cheio;
    assign pop_ok    = pop & ~vazio;
    assign dado_head = mem[rd_ptr];

    // Pointer step with explicit wrap so a depth of 1 also works
    function automatic logic [AW-1:0] avanca(input logic [AW-1:0] p);
        return (p == ULT) ? '0 : p + 1'b1;
    endfunction

    // Storage write; contents need no reset since occupancy gates every read
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= dado_in;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ocupacao <= 4'd0;
        end else begin
            if (push_ok) wr_ptr <= avanca(wr_ptr);
            if (pop_ok)  rd_ptr <= avanca(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   ocupacao <= ocupacao + 4'd1;
                2'b01:   ocupacao <= ocupacao - 4'd1;
                default: ocupacao <= ocupacao;
            endcase
        end
    end

endmodule

// File: rtl/porta_entrada_fifo.sv
// Memory-mapped input port: producer pushes into a FIFO, processor pops via data/status reads.
// Latency: 1 cycle from read strobe to dado_out.
// Backpressure: entrada_pronta low while full or in reset; reads of an empty FIFO set underrun.
module porta_entrada_fifo #(
    parameter int         PROFUNDIDADE = 4,
    parameter logic [7:0] END_DADO     = porta_entrada_fifo_pkg::END_DADO,
    parameter logic [7:0] END_STATUS   = porta_entrada_fifo_pkg::END_STATUS
) (
    input  logic                  clock,
    input  logic                  reset,
    porta_entrada_fifo_if.slave   bus
);
    import porta_entrada_fifo_pkg::*;

    byte_t      dado_head;
    byte_t      dado_q;
    logic       cheio;
    logic       vazio;
    logic [3:0] ocupacao;
    logic       underrun;
    logic       rd_dado;
    logic       rd_status;
    logic       push;
    logic       pop;

    assign rd_dado   = bus.leitura & (bus.endereco == END_DADO);
    assign rd_status = bus.leitura & (bus.endereco == END_STATUS);

    // Ready depends only on registered state and the reset pin, never on entrada_valida
    assign bus.entrada_pronta = reset & ~cheio;
    assign bus.nao_vazio      = ~vazio;
    assign bus.dado_out       = dado_q;

    assign push = bus.entrada_valida & bus.entrada_pronta;
    assign pop  = rd_dado & ~vazio;

    fifo_sincrona #(
        .PROFUNDIDADE (PROFUNDIDADE),
        .LARGURA      (8)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .dado_in   (bus.entrada),
        .pop       (pop),
        .dado_head (dado_head),
        .cheio     (cheio),
        .vazio     (vazio),
        .ocupacao  (ocupacao)
    );

    // Read data register and sticky underrun; other addresses leave both untouched
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dado_q   <= 8'h00;
            underrun <= 1'b0;
        end else if (rd_dado) begin
            if (!vazio) begin
                dado_q <= dado_head;
            end else begin
                dado_q   <= 8'h00;
                underrun <= 1'b1;
            end
        end else if (rd_status) begin
            dado_q   <= monta_status(~vazio, cheio, underrun, ocupacao[2:0]);
            underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_porta_entrada_fifo.sv
// Bench for the memory-mapped input port: directed scenarios then random traffic vs a queue model.
// Latency: checks dado_out one cycle after each strobe and that it holds before the edge.
// Backpressure: model accepts a push only when fewer than DEPTH bytes are held.
module tb_porta_entrada_fifo;
    import porta_entrada_fifo_pkg::*;

    localparam int DEPTH = 4;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    porta_entrada_fifo_if bus ();

    porta_entrada_fifo #(
        .PROFUNDIDADE (DEPTH),
        .END_DADO     (END_DADO),
        .END_STATUS   (END_STATUS)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: byte queue, sticky underrun, last read value
    logic [7:0] q [$];
    logic       und_m;
    logic [7:0] dado_m;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive at negedge, check pre-edge hold, apply model, check after edge
    task automatic step(input logic v, input logic [7:0] b, input logic rd, input logic [7:0] a);
        int n;
        @(negedge clock);
        bus.entrada_valida = v;
        bus.entrada        = b;
        bus.leitura        = rd;
        bus.endereco       = a;
        #1;
        check("pronta_pre", {7'd0, bus.entrada_pronta}, {7'd0, q.size() != DEPTH});
        check("hold_pre", bus.dado_out, dado_m);
        @(posedge clock);
        n = q.size();
        if (rd && a == END_DADO) begin
            if (n > 0) dado_m = q.pop_front();
            else begin
                dado_m = 8'h00;
                und_m  = 1'b1;
            end
        end else if (rd && a == END_STATUS) begin
            dado_m = {n != 0, n == DEPTH, und_m, 2'b00, 3'(n)};
            und_m  = 1'b0;
        end
        if (v && n < DEPTH) q.push_back(b);
        #1;
        check("dado_out", bus.dado_out, dado_m);
        check("nao_vazio", {7'd0, bus.nao_vazio}, {7'd0, q.size() != 0});
        check("pronta_post", {7'd0, bus.entrada_pronta}, {7'd0, q.size() != DEPTH});
    endtask

    initial begin
        logic [7:0] ra;
        total = 0;
        bad   = 0;
        q.delete();
        und_m  = 1'b0;
        dado_m = 8'h00;
        reset  = 1'b0;
        bus.entrada        = 8'h00;
        bus.entrada_valida = 1'b0;
        bus.leitura        = 1'b0;
        bus.endereco       = 8'h00;

        // Reset state
        #3;
        check("rst_dado", bus.dado_out, 8'h00);
        check("rst_pronta", {7'd0, bus.entrada_pronta}, 8'h00);
        check("rst_nv", {7'd0, bus.nao_vazio}, 8'h00);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
        check("rel_pronta", {7'd0, bus.entrada_pronta}, 8'h01);

        // Two pushes, status, two reads, empty status
        step(1'b1, 8'hA5, 1'b0, 8'h00);
        step(1'b1, 8'h3C, 1'b0, 8'h00);
        step(1'b0, 8'h00, 1'b1, END_STATUS);
        check("st_82", bus.dado_out, 8'h82);
        step(1'b0, 8'h00, 1'b1, END_DADO);
        check("rd_a5", bus.dado_out, 8'hA5);
        step(1'b0, 8'h00, 1'b1, END_DADO);
        check("rd_3c", bus.dado_out, 8'h3C);
        step(1'b0, 8'h00, 1'b1, END_STATUS);
        check("st_00", bus.dado_out, 8'h00);

        // Fill, full status, held fifth byte lands after one pop
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 8'h00);
        check("full_pronta", {7'd0, bus.entrada_pronta}, 8'h00);
        step(1'b0, 8'h00, 1'b1, END_STATUS);
        check("st_c4", bus.dado_out, 8'hC4);
        step(1'b1, 8'h05, 1'b1, END_DADO);
        check("rd_01", bus.dado_out, 8'h01);
        step(1'b1, 8'h05, 1'b0, 8'h00);
        for (int i = 2; i <= 5; i++) begin
            step(1'b0, 8'h00, 1'b1, END_DADO);
            check("rd_seq", bus.dado_out, 8'(i));
        end

        // Underrun, sticky flag, cleared by status read
        step(1'b0, 8'h00, 1'b1, END_DADO);
        check("und_dado", bus.dado_out, 8'h00);
        step(1'b0, 8'h00, 1'b1, END_STATUS);
        check("st_20", bus.dado_out, 8'h20);
        step(1'b0, 8'h00, 1'b1, END_STATUS);
        check("st_clr", bus.dado_out, 8'h00);

        // Push and pop together with two bytes held
        step(1'b1, 8'h11, 1'b0, 8'h00);
        step(1'b1, 8'h22, 1'b0, 8'h00);
        step(1'b1, 8'h77, 1'b1, END_DADO);
        check("pp_head", bus.dado_out, 8'h11);
        step(1'b0, 8'h00, 1'b1, END_STATUS);
        check("pp_st", bus.dado_out, 8'h82);
        step(1'b0, 8'h00, 1'b1, END_DADO);
        check("pp_22", bus.dado_out, 8'h22);
        step(1'b0, 8'h00, 1'b1, END_DADO);
        check("pp_77", bus.dado_out, 8'h77);

        // Push and pop together while empty: underrun, push still lands
        step(1'b1, 8'h99, 1'b1, END_DADO);
        check("ep_dado", bus.dado_out, 8'h00);
        step(1'b0, 8'h00, 1'b1, END_STATUS);
        check("ep_st", bus.dado_out, 8'hA1);
        step(1'b0, 8'h00, 1'b1, END_DADO);
        check("ep_99", bus.dado_out, 8'h99);

        // Unmapped address leaves dado_out and FIFO alone
        step(1'b1, 8'hAA, 1'b0, 8'h00);
        step(1'b1, 8'hBB, 1'b0, 8'h00);
        step(1'b0, 8'h00, 1'b1, END_DADO);
        step(1'b0, 8'h00, 1'b1, 8'hE0);
        check("e0_hold", bus.dado_out, 8'hAA);
        step(1'b0, 8'h00, 1'b1, END_STATUS);
        check("e0_st", bus.dado_out, 8'h81);

        // Reset mid-stream with three bytes held and a handshake in flight
        step(1'b1, 8'hC1, 1'b0, 8'h00);
        step(1'b1, 8'hC2, 1'b0, 8'h00);
        @(negedge clock);
        bus.entrada_valida = 1'b1;
        bus.entrada        = 8'hC3;
        bus.leitura        = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("mid_dado", bus.dado_out, 8'h00);
        check("mid_pronta", {7'd0, bus.entrada_pronta}, 8'h00);
        check("mid_nv", {7'd0, bus.nao_vazio}, 8'h00);
        q.delete();
        und_m  = 1'b0;
        dado_m = 8'h00;
        @(negedge clock);
        bus.entrada_valida = 1'b0;
        reset = 1'b1;
        #1;
        check("mid_rel", {7'd0, bus.entrada_pronta}, 8'h01);
        step(1'b0, 8'h00, 1'b1, END_STATUS);
        check("mid_st", bus.dado_out, 8'h00);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       ra = END_DADO;
                1:       ra = END_STATUS;
                2:       ra = 8'hE0;
                default: ra = 8'($urandom);
            endcase
            step($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 1) == 1, ra);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
